// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// mem_stage_ctrl: MEM-stage sequencer that issues one data-memory request per load/store,
// stalls the pipeline until ack or timeout, and registers the writeback fields. Rev 1.0
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_mem_to_reg,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_wb_data,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d;
  logic [31:0]      dmem_wdata_q, dmem_wdata_d;
  logic [4:0]       rd_lat_q, rd_lat_d;
  logic             m2r_lat_q, m2r_lat_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_wb_data_q, out_wb_data_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_m2r_q, out_m2r_d;
  logic             misalign_q, misalign_d;
  logic             timeout_q, timeout_d;
  logic             stall_c;

  logic access, aligned, ack_v;
  assign access  = in_mem_read | in_mem_write;
  assign aligned = (in_alu_result[1:0] == 2'b00);
  // An ack is only meaningful while a request is outstanding.
  assign ack_v   = dmem_ack & dmem_req_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    rd_lat_d      = rd_lat_q;
    m2r_lat_d     = m2r_lat_q;
    out_valid_d   = out_valid_q;
    out_wb_data_d = out_wb_data_q;
    out_rd_d      = out_rd_q;
    out_m2r_d     = out_m2r_q;
    misalign_d    = 1'b0;
    timeout_d     = 1'b0;
    stall_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access && aligned) begin
          stall_c      = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = in_mem_write;
          dmem_addr_d  = in_alu_result;
          dmem_wdata_d = in_store_data;
          rd_lat_d     = in_rd;
          m2r_lat_d    = in_mem_to_reg & ~in_mem_write;
          cnt_d        = '0;
          out_valid_d  = 1'b0;
          state_d      = S_BUSY;
        end else if (access) begin
          out_valid_d   = 1'b1;
          misalign_d    = 1'b1;
          out_rd_d      = 5'd0;
          out_m2r_d     = 1'b0;
          out_wb_data_d = in_alu_result;
        end else begin
          out_valid_d   = 1'b1;
          out_wb_data_d = in_alu_result;
          out_rd_d      = in_rd;
          out_m2r_d     = 1'b0;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        // Ack is tested first so it wins over a coincident timeout.
        if (ack_v) begin
          dmem_req_d    = 1'b0;
          dmem_we_d     = 1'b0;
          out_valid_d   = 1'b1;
          out_wb_data_d = m2r_lat_q ? dmem_rdata : dmem_addr_q;
          out_rd_d      = rd_lat_q;
          out_m2r_d     = m2r_lat_q;
          state_d       = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          timeout_d   = 1'b1;
          out_valid_d = 1'b1;
          out_rd_d    = 5'd0;
          out_m2r_d   = 1'b0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= 32'd0;
      dmem_wdata_q  <= 32'd0;
      rd_lat_q      <= 5'd0;
      m2r_lat_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_wb_data_q <= 32'd0;
      out_rd_q      <= 5'd0;
      out_m2r_q     <= 1'b0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      rd_lat_q      <= rd_lat_d;
      m2r_lat_q     <= m2r_lat_d;
      out_valid_q   <= out_valid_d;
      out_wb_data_q <= out_wb_data_d;
      out_rd_q      <= out_rd_d;
      out_m2r_q     <= out_m2r_d;
      misalign_q    <= misalign_d;
      timeout_q     <= timeout_d;
    end
  end

  assign stall          = reset & stall_c;
  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign out_valid      = out_valid_q;
  assign out_wb_data    = out_wb_data_q;
  assign out_rd         = out_rd_q;
  assign out_mem_to_reg = out_m2r_q;
  assign misalign_err   = misalign_q;
  assign timeout_err    = timeout_q;

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, is the maximum number of BUSY cycles spent waiting for dmem_ack before aborting.
REQ-002 Port: clk  in  1  single clock, all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port: in_mem_read, in_mem_write, in_mem_to_reg  in  1 each  control bits from the EX/MEM register outputs.
REQ-005 Port: in_alu_result  in  32  effective address for memory ops, or the result for non-memory ops.
REQ-006 Port: in_store_data  in  32  store data; in_rd  in  5  destination register.
REQ-007 Port: stall  out  1  combinational; when high, the EX/MEM register and upstream stages hold.
REQ-008 Port: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32  registered data-memory request.
REQ-009 Port: dmem_ack  in  1; dmem_rdata  in  32  memory completion and read data, valid in the ack cycle.
REQ-010 Port: out_valid  out  1  one-cycle pulse per retired instruction.
REQ-011 Port: out_wb_data  out  32; out_rd  out  5; out_mem_to_reg  out  1  registered writeback fields.
REQ-012 Port: misalign_err  out  1; timeout_err  out  1  one-cycle error pulses.

Function
REQ-013 The FSM SHALL have three states, IDLE, BUSY and DONE, encoded in 2 bits; the unused code SHALL return to IDLE.
REQ-014 access = in_mem_read | in_mem_write; aligned = (in_alu_result[1:0] == 0); write = in_mem_write (write SHALL take priority when both read and write are high).
REQ-015 In IDLE with access and aligned: stall=1; at the clock edge, latch addr, wdata, we=write, rd, mem_to_reg & ~write; then dmem_req<=1 and go to BUSY; out_valid<=0.
REQ-016 In IDLE without access: stall=0; at the edge, out_valid<=1, out_wb_data<=in_alu_result, out_rd<=in_rd, out_mem_to_reg<=0; the FSM stays in IDLE (bubbles included).
REQ-017 In IDLE with access and misaligned: stall=0, no bus request; at the edge, out_valid<=1, misalign_err<=1, out_rd<=0, out_mem_to_reg<=0, out_wb_data<=in_alu_result.
REQ-018 In BUSY: stall=1; dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable until ack or timeout.
REQ-019 In BUSY with dmem_ack=1: dmem_req<=0; out_valid<=1; out_wb_data<=(latched mem_to_reg ? dmem_rdata : addr); out_rd<=latched rd; out_mem_to_reg<=latched mem_to_reg; go to DONE.
REQ-020 Zero-wait memory (ack in the first BUSY cycle) SHALL give a load/store occupancy of IDLE(stall)+BUSY(stall)+DONE = 3 cycles.
REQ-021 The wait counter (width clog2(TIMEOUT_CYCLES)+1) SHALL clear on entry to BUSY and increment on each BUSY cycle without ack.
REQ-022 In BUSY, when the counter reaches TIMEOUT_CYCLES-1 with no ack: dmem_req<=0, timeout_err<=1, out_valid<=1, out_rd<=0, out_mem_to_reg<=0; go to DONE.
REQ-023 If ack and timeout occur in the same cycle, ack SHALL win and timeout_err SHALL stay 0.
REQ-024 In DONE: stall=0 and the inputs are ignored (the EX/MEM register still holds the completed instruction); go to IDLE next cycle with out_valid<=0.
REQ-025 dmem_ack SHALL be ignored whenever dmem_req=0.
REQ-026 misalign_err and timeout_err SHALL be high for exactly one cycle and clear on the next edge.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, counter=0, and all registered outputs (dmem_*, out_*, *_err) to 0, including mid-BUSY (dmem_req drops asynchronously).
REQ-028 While reset=0, stall SHALL be 0.
REQ-029 After reset release, the first edge SHALL evaluate the inputs as in IDLE.

Verification
REQ-030 ALU op: mem_read=0, mem_write=0, alu=0x0000_1234, rd=5 -> next cycle out_valid=1, wb_data=0x1234, rd=5, stall never high.
REQ-031 Load at 0x100, ack after 2 BUSY cycles, rdata=0xDEAD_BEEF, rd=7, mem_to_reg=1 -> stall high for 3 cycles; dmem_addr=0x100 stable; in DONE out_valid=1, wb_data=0xDEADBEEF, rd=7.
REQ-032 Store at 0x204, data 0xCAFE_F00D, zero-wait ack -> dmem_we=1, wdata=0xCAFEF00D for 1 BUSY cycle, out_mem_to_reg=0, total occupancy 3 cycles.
REQ-033 Load at 0x102 -> no dmem_req, misalign_err pulse, out_rd=0, stall=0.
REQ-034 Load with no ack and TIMEOUT_CYCLES=16 -> dmem_req high for exactly 16 cycles, then timeout_err pulse and out_rd=0; a second run with ack in cycle 16 -> normal completion, no timeout_err.
REQ-035 Reset asserted in the 2nd BUSY cycle -> dmem_req=0 and stall=0 immediately; after release, an ALU op retires normally.
